// File: rtl/cl_row_reader.sv
// Row reader: fetches one flag row per line from bank A or B and streams it out
// as pixel pairs with VSYNC/HSYNC/DE framing. All outputs are registered.
module cl_row_reader #(
  parameter int ADDR_WIDTH  = 11,
  parameter int MDATA_WIDTH = 640,
  parameter int PIXEL_WIDTH = 8,
  parameter int HBLANK      = 4
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic                   iSTART,
  input  logic                   iMEM_SEL,
  input  logic [ADDR_WIDTH-1:0]  iHSIZE,
  input  logic [ADDR_WIDTH-1:0]  iVSIZE,
  input  logic [MDATA_WIDTH-1:0] iRDATA_A,
  input  logic [MDATA_WIDTH-1:0] iRDATA_B,
  output logic                   oREA,
  output logic                   oREB,
  output logic [ADDR_WIDTH-1:0]  oRD_ADDR,
  output logic                   oVSYNC,
  output logic                   oHSYNC,
  output logic                   oDE,
  output logic [PIXEL_WIDTH-1:0] oDATA_L,
  output logic [PIXEL_WIDTH-1:0] oDATA_R,
  output logic                   oBUSY,
  output logic                   oFRAME_DONE
);

  // state | meaning
  // IDLE  | waiting for an accepted iSTART
  // FETCH | read enable + row address to the selected bank
  // LOAD  | capture the returned row, emit pair 0 on the next cycle
  // ACT   | stream pixel pairs (DE high), pair counter counts down
  // HBL   | horizontal blanking, then next row or end of frame
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ACT, HBL} state_t;

  localparam logic [ADDR_WIDTH-1:0] MDW      = ADDR_WIDTH'(MDATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] HBL_LOAD = ADDR_WIDTH'(HBLANK - 1);

  state_t                 state_q, state_n;
  logic                   sel_q, sel_n;
  logic [ADDR_WIDTH-1:0]  hsize_q, hsize_n;
  logic [ADDR_WIDTH-1:0]  vsize_q, vsize_n;
  logic [ADDR_WIDTH-1:0]  row_q, row_n;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_n;
  logic [MDATA_WIDTH-1:0] shreg_q, shreg_n;

  logic [ADDR_WIDTH-1:0]  hsize_clip, hsize_eff, addr_n;
  logic [MDATA_WIDTH-1:0] rdata;
  logic [PIXEL_WIDTH-1:0] data_l_n, data_r_n;
  logic                   start_ok, done_n, rea_n, reb_n, vsync_n, de_n;

  function automatic logic [PIXEL_WIDTH-1:0] pix(input logic flag);
    return {PIXEL_WIDTH{~flag}};
  endfunction

  assign hsize_clip = (iHSIZE > MDW) ? MDW : iHSIZE;
  assign hsize_eff  = {hsize_clip[ADDR_WIDTH-1:1], 1'b0};
  assign start_ok   = iSTART && (iVSIZE != '0) && (hsize_eff >= TWO);
  assign rdata      = sel_q ? iRDATA_B : iRDATA_A;

  always_comb begin
    state_n  = state_q;
    sel_n    = sel_q;
    hsize_n  = hsize_q;
    vsize_n  = vsize_q;
    row_n    = row_q;
    cnt_n    = cnt_q;
    shreg_n  = shreg_q;
    data_l_n = '0;
    data_r_n = '0;
    done_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          sel_n   = iMEM_SEL;
          hsize_n = hsize_eff;
          vsize_n = iVSIZE;
          row_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        // pair 0 goes straight from the read data so DE starts the next cycle
        data_l_n = pix(rdata[0]);
        data_r_n = pix(rdata[1]);
        shreg_n  = rdata >> 2;
        cnt_n    = (hsize_q >> 1) - ONE;
        state_n  = ACT;
      end
      ACT: begin
        if (cnt_q == '0) begin
          cnt_n   = HBL_LOAD;
          state_n = HBL;
        end else begin
          cnt_n    = cnt_q - ONE;
          data_l_n = pix(shreg_q[0]);
          data_r_n = pix(shreg_q[1]);
          shreg_n  = shreg_q >> 2;
        end
      end
      HBL: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - ONE;
        end else if (row_q == vsize_q - ONE) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          row_n   = row_q + ONE;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    vsync_n = (state_n != IDLE);
    rea_n   = (state_n == FETCH) && !sel_n;
    reb_n   = (state_n == FETCH) && sel_n;
    addr_n  = (state_n == FETCH) ? row_n : '0;
    de_n    = (state_n == ACT);
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      hsize_q     <= '0;
      vsize_q     <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      oREA        <= 1'b0;
      oREB        <= 1'b0;
      oRD_ADDR    <= '0;
      oVSYNC      <= 1'b0;
      oHSYNC      <= 1'b0;
      oDE         <= 1'b0;
      oDATA_L     <= '0;
      oDATA_R     <= '0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      state_q     <= state_n;
      sel_q       <= sel_n;
      hsize_q     <= hsize_n;
      vsize_q     <= vsize_n;
      row_q       <= row_n;
      cnt_q       <= cnt_n;
      shreg_q     <= shreg_n;
      oREA        <= rea_n;
      oREB        <= reb_n;
      oRD_ADDR    <= addr_n;
      oVSYNC      <= vsync_n;
      oHSYNC      <= de_n;
      oDE         <= de_n;
      oDATA_L     <= data_l_n;
      oDATA_R     <= data_r_n;
      oBUSY       <= vsync_n;
      oFRAME_DONE <= done_n;
    end
  end

endmodule

// File: tb/tb_cl_row_reader.sv
// Directed bench for cl_row_reader: bank memories with 1-cycle read latency and a
// threshold receiver that rebuilds flag rows from the pixel stream.
module tb_cl_row_reader;
  localparam int AW = 11;
  localparam int MW = 640;
  localparam int PW = 8;

  logic          CCLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          iSTART = 1'b0;
  logic          iMEM_SEL = 1'b0;
  logic [AW-1:0] iHSIZE = '0;
  logic [AW-1:0] iVSIZE = '0;
  logic [MW-1:0] iRDATA_A = '0;
  logic [MW-1:0] iRDATA_B = '0;
  logic          oREA, oREB, oVSYNC, oHSYNC, oDE, oBUSY, oFRAME_DONE;
  logic [AW-1:0] oRD_ADDR;
  logic [PW-1:0] oDATA_L, oDATA_R;

  logic [MW-1:0] mem_a [0:3];
  logic [MW-1:0] mem_b [0:3];

  int errors = 0;
  int checks = 0;

  // receiver state
  logic [15:0] cap [0:3];
  int cap_rows = 0, cap_pix = 0, last_pairs = 0;
  logic hs_d = 1'b0, vs_d = 1'b0;

  cl_row_reader #(.ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .PIXEL_WIDTH(PW), .HBLANK(4)) dut (
    .CCLK(CCLK), .RST_N(RST_N), .iSTART(iSTART), .iMEM_SEL(iMEM_SEL),
    .iHSIZE(iHSIZE), .iVSIZE(iVSIZE), .iRDATA_A(iRDATA_A), .iRDATA_B(iRDATA_B),
    .oREA(oREA), .oREB(oREB), .oRD_ADDR(oRD_ADDR), .oVSYNC(oVSYNC), .oHSYNC(oHSYNC),
    .oDE(oDE), .oDATA_L(oDATA_L), .oDATA_R(oDATA_R), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 CCLK = ~CCLK;

  always @(posedge CCLK) begin
    if (oREA) iRDATA_A <= mem_a[oRD_ADDR[1:0]];
    if (oREB) iRDATA_B <= mem_b[oRD_ADDR[1:0]];
  end

  always @(negedge CCLK) begin
    if (oVSYNC && !vs_d) begin
      cap_rows = 0;
      cap_pix  = 0;
      for (int i = 0; i < 4; i++) cap[i] = '0;
    end
    if (oDE) begin
      if (cap_rows < 4 && cap_pix < 15) begin
        cap[cap_rows][cap_pix]   = (oDATA_L < 8'h80);
        cap[cap_rows][cap_pix+1] = (oDATA_R < 8'h80);
      end
      cap_pix += 2;
    end
    if (!oHSYNC && hs_d) begin
      last_pairs = cap_pix / 2;
      cap_rows++;
      cap_pix = 0;
    end
    hs_d = oHSYNC;
    vs_d = oVSYNC;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic start_frame(input logic sel, input int hs, input int vs);
    iMEM_SEL = sel;
    iHSIZE   = AW'(hs);
    iVSIZE   = AW'(vs);
    iSTART   = 1'b1;
    tick();
    iSTART   = 1'b0;
  endtask

  // Runs from the cycle after the start edge until VSYNC falls (or budget expires).
  task automatic run_frame(input int max, input int pulse_at,
                           output int vs_c, output int rea_c, output int reb_c,
                           output int de_c, output int fd_c, output int bad_c, output int ended);
    bit seen = 0;
    vs_c = 0; rea_c = 0; reb_c = 0; de_c = 0; fd_c = 0; bad_c = 0; ended = 0;
    for (int i = 0; i < max; i++) begin
      vs_c  += int'(oVSYNC);
      rea_c += int'(oREA);
      reb_c += int'(oREB);
      de_c  += int'(oDE);
      fd_c  += int'(oFRAME_DONE);
      if ((oREA && oREB) || (!oDE && (oDATA_L != 0 || oDATA_R != 0)) || (oBUSY != oVSYNC))
        bad_c++;
      if (oVSYNC) seen = 1;
      if (seen && !oVSYNC) begin
        ended = 1;
        break;
      end
      iSTART = (i == pulse_at);
      tick();
    end
    iSTART = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_vsync"}, 32'(oVSYNC), 0);
    chk({tag, "_busy"},  32'(oBUSY), 0);
    chk({tag, "_de"},    32'({oDE, oHSYNC}), 0);
    chk({tag, "_re"},    32'({oREA, oREB}), 0);
    chk({tag, "_addr"},  32'(oRD_ADDR), 0);
    chk({tag, "_data"},  32'({oDATA_L, oDATA_R}), 0);
    chk({tag, "_done"},  32'(oFRAME_DONE), 0);
  endtask

  initial begin
    int vs_c, rea_c, reb_c, de_c, fd_c, bad_c, ended;
    logic exp_vs, exp_re, exp_de, exp_fd, fl, fr;
    logic [AW-1:0] exp_addr;
    logic [PW-1:0] exp_l, exp_r;
    int r, p;

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = MW'(8'h0F);
    mem_a[1] = MW'(8'hF0);
    mem_b[0] = MW'(4'h5);
    mem_b[1] = MW'(4'hC);
    mem_b[2] = MW'(4'h9);
    mem_a[2] = {MW{1'b1}};

    // reset
    tick();
    tick();
    chk_idle_outputs("rst");
    @(negedge CCLK);
    RST_N = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_busy", 32'(oBUSY), 0);

    // basic frame on bank A, cycle by cycle
    start_frame(1'b0, 8, 2);
    for (int k = 1; k <= 22; k++) begin
      exp_vs   = (k >= 1 && k <= 20);
      exp_re   = (k == 1 || k == 11);
      exp_addr = (k == 11) ? AW'(1) : AW'(0);
      exp_de   = (k >= 3 && k <= 6) || (k >= 13 && k <= 16);
      exp_fd   = (k == 21);
      exp_l = '0;
      exp_r = '0;
      if (exp_de) begin
        r  = (k >= 13) ? 1 : 0;
        p  = k - (r == 1 ? 13 : 3);
        fl = mem_a[r][2*p];
        fr = mem_a[r][2*p+1];
        exp_l = fl ? 8'h00 : 8'hFF;
        exp_r = fr ? 8'h00 : 8'hFF;
      end
      chk($sformatf("A_vsync_%0d", k), 32'(oVSYNC), 32'(exp_vs));
      chk($sformatf("A_busy_%0d", k),  32'(oBUSY), 32'(exp_vs));
      chk($sformatf("A_rea_%0d", k),   32'(oREA), 32'(exp_re));
      chk($sformatf("A_reb_%0d", k),   32'(oREB), 0);
      chk($sformatf("A_addr_%0d", k),  32'(oRD_ADDR), 32'(exp_addr));
      chk($sformatf("A_de_%0d", k),    32'({oDE, oHSYNC}), 32'({exp_de, exp_de}));
      chk($sformatf("A_data_%0d", k),  32'({oDATA_L, oDATA_R}), 32'({exp_l, exp_r}));
      chk($sformatf("A_done_%0d", k),  32'(oFRAME_DONE), 32'(exp_fd));
      if (k == 3) chk("A_pair0", 32'({oDATA_L, oDATA_R}), 32'h0000);
      if (k == 5) chk("A_pair2", 32'({oDATA_L, oDATA_R}), 32'hFFFF);
      if (k == 13) chk("A_row1_pair0", 32'({oDATA_L, oDATA_R}), 32'hFFFF);
      if (k == 16) chk("A_row1_pair3", 32'({oDATA_L, oDATA_R}), 32'h0000);
      tick();
    end
    chk("A_loop_rows", 32'(cap_rows), 2);
    chk("A_loop_row0", 32'(cap[0][7:0]), 32'h0F);
    chk("A_loop_row1", 32'(cap[1][7:0]), 32'hF0);

    // bank B with mid-frame changes to select/size inputs
    start_frame(1'b1, 4, 3);
    iMEM_SEL = 1'b0;
    iHSIZE   = AW'(20);
    iVSIZE   = AW'(1);
    run_frame(200, -1, vs_c, rea_c, reb_c, de_c, fd_c, bad_c, ended);
    chk("B_ended", 32'(ended), 1);
    chk("B_rea", 32'(rea_c), 0);
    chk("B_reb", 32'(reb_c), 3);
    chk("B_vs_len", 32'(vs_c), 24);
    chk("B_de", 32'(de_c), 6);
    chk("B_done", 32'(fd_c), 1);
    chk("B_invariants", 32'(bad_c), 0);
    chk("B_loop_rows", 32'(cap_rows), 3);
    chk("B_loop_row0", 32'(cap[0][3:0]), 32'h5);
    chk("B_loop_row1", 32'(cap[1][3:0]), 32'hC);
    chk("B_loop_row2", 32'(cap[2][3:0]), 32'h9);
    tick();

    // odd HSIZE rounds down
    start_frame(1'b0, 9, 1);
    run_frame(200, -1, vs_c, rea_c, reb_c, de_c, fd_c, bad_c, ended);
    chk("C_ended", 32'(ended), 1);
    chk("C_de", 32'(de_c), 4);
    chk("C_vs_len", 32'(vs_c), 10);
    chk("C_rea", 32'(rea_c), 1);
    tick();

    // rejected starts
    start_frame(1'b0, 1, 1);
    tick(); tick();
    chk("D_hsize1_busy", 32'(oBUSY), 0);
    start_frame(1'b0, 4, 0);
    tick(); tick();
    chk("D_vsize0_busy", 32'(oBUSY), 0);
    chk("D_vsize0_re", 32'({oREA, oREB}), 0);

    // HSIZE clipped to memory width
    start_frame(1'b0, 2000, 1);
    run_frame(1000, -1, vs_c, rea_c, reb_c, de_c, fd_c, bad_c, ended);
    chk("E_ended", 32'(ended), 1);
    chk("E_de", 32'(de_c), 320);
    chk("E_pairs_row", 32'(last_pairs), 320);
    chk("E_vs_len", 32'(vs_c), 326);
    tick();

    // repeated iSTART mid-frame ignored
    start_frame(1'b0, 4, 2);
    run_frame(200, 5, vs_c, rea_c, reb_c, de_c, fd_c, bad_c, ended);
    chk("F_ended", 32'(ended), 1);
    chk("F_vs_len", 32'(vs_c), 16);
    chk("F_done", 32'(fd_c), 1);
    chk("F_rea", 32'(rea_c), 2);
    tick(); tick(); tick();
    chk("F_no_restart", 32'(oBUSY), 0);

    // async reset during ACT
    start_frame(1'b0, 8, 2);
    tick(); tick();
    chk("G_in_act", 32'(oDE), 1);
    RST_N = 1'b0;
    #1;
    chk_idle_outputs("G_rst");
    tick();
    @(negedge CCLK);
    RST_N = 1'b1;
    tick(); tick(); tick(); tick();
    chk("G_after_busy", 32'(oBUSY), 0);
    chk("G_after_re", 32'({oREA, oREB}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
